seg7_reader: RTL
================

Name: seg7_reader

Overview:
- Receive end of the display path: samples the 7-segment pattern C0..C6 produced by the team's BCD-to-segment encoder and recovers the 4-bit digit.
- Filters glitches with a stability window.
- Reports each new stable pattern once, on a valid/ready handshake.
- Used for display loop-back self-check and for reading segment buses from other boards.

Parameters:
- STABLE_CYCLES, 4, consecutive sampling edges a pattern must hold before it qualifies; legal range 1..255.
- CNT_W, $clog2(STABLE_CYCLES+1), stability counter width; derived, not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- seg_in  in  7  segment pattern, bit i = Ci (bit0 = segment a ... bit6 = segment g), active-high.
- out_digit  out  4  decoded digit 0..9; 4'hF when invalid.
- out_err  out  1  qualified pattern is not a legal digit.
- out_valid  out  1  out_digit/out_err hold a pending report.
- out_ready  in  1  consumer accepts the report when out_valid & out_ready.
- overrun  out  1  sticky: a report was dropped because the previous one was still pending.
- clr_overrun  in  1  clears overrun.

Behaviour:
- Reset, sampled with reset==0 at a clk edge:
  - out_digit=0, out_err=0, out_valid=0, overrun=0.
  - cand=0, cnt=0, last=7'h00 (blank), state=SETTLE.
- Legal patterns:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=67 (hex).
  - BLANK=00.
  - Any other value is invalid.
- Stability filter, per edge:
  - If seg_in != cand: cand<=seg_in, cnt<=1.
  - Otherwise cnt increments, saturating at STABLE_CYCLES.
  - A pattern qualifies at the edge where cnt would reach STABLE_CYCLES.
  - Pattern present before edges k..k+STABLE_CYCLES-1 qualifies at edge k+STABLE_CYCLES-1.
  - With STABLE_CYCLES=1, it qualifies at the first edge it is seen.
- FSM:
  - SETTLE: waits for qualification. On qualify go to LOCKED and, if cand != last, generate a report event and set last<=cand.
  - LOCKED: stays while seg_in==cand. On any change go to SETTLE (cnt<=1, cand<=seg_in).
  - A pattern that re-qualifies equal to last produces no event, so glitches do not duplicate reports.
- BLANK qualifying: last<=BLANK and no report is generated. The same digit shown after a blank is reported again.
- Report event:
  - out_digit <= decode(cand), out_err <= invalid(cand), out_valid<=1, visible the cycle after the qualifying edge.
  - Invalid pattern: out_digit=4'hF, out_err=1.
- Handshake:
  - out_valid stays high and out_digit/out_err stay stable until a cycle with out_ready=1.
  - At that edge out_valid clears, unless a new event occurs at the same edge. In that case the new report loads and out_valid stays 1; this is not an overrun.
- Overrun:
  - An event with out_valid=1 and out_ready=0 is dropped; the pending report is kept and overrun<=1.
  - clr_overrun=1 clears overrun. If clr_overrun and a new overrun occur in the same cycle, overrun is set (set wins).
- Reset mid-operation discards the pending report and the stability history. The pattern currently on seg_in is reported again after STABLE_CYCLES edges.
- Latency: pattern change to out_valid is STABLE_CYCLES edges; no combinational path from seg_in to any output.

Decomposition:
- seg7_pkg:
  - SEG_0..SEG_9 and SEG_BLANK pattern constants (7-bit).
  - DIGIT_ERR=4'hF.
  - State enum {SETTLE, LOCKED}.
- Sub-module seg7_decode: purely combinational, seg[6:0] -> digit[3:0], invalid. Shared with future loop-back checkers.

Test Plan:
- STABLE_CYCLES=4, out_ready=1; drive 3F,06,5B,4F,66,6D,7D,07,7F,67, each held 6 cycles -> ten 1-cycle out_valid pulses with out_digit 0..9, out_err=0, each 4 edges after the change.
- Hold 6D (reporting 5), then insert 7F for 2 cycles, then return to 6D -> no report for 8 and no second report of 5.
- Drive 49 for 5 cycles -> one report with out_digit=F, out_err=1.
- Hold 06 (reporting 1), then 00 for 5 cycles, then 06 again -> a second report of 1; no report for the blank.
- out_ready=0; qualify 4F, then 66 -> out_digit stays 3, overrun=1. Then out_ready=1 -> 3 accepted, out_valid=0. clr_overrun pulse -> overrun=0.
- Drive reset=0 for 1 edge while 7D is pending -> out_valid=0, overrun=0. With 7D held, report 6 reappears 4 edges after reset releases.

Source files
------------

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - segment pattern constants and reader state type
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h67;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] DIGIT_ERR = 4'hF;

  typedef enum logic {
    SETTLE,
    LOCKED
  } state_t;

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational 7-segment pattern to BCD digit decoder
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] digit,
  output logic       invalid
);

  // Blank is not a digit; callers that treat blank specially filter it first.
  always_comb begin
    digit   = DIGIT_ERR;
    invalid = 1'b1;
    case (seg)
      SEG_0: begin digit = 4'd0; invalid = 1'b0; end
      SEG_1: begin digit = 4'd1; invalid = 1'b0; end
      SEG_2: begin digit = 4'd2; invalid = 1'b0; end
      SEG_3: begin digit = 4'd3; invalid = 1'b0; end
      SEG_4: begin digit = 4'd4; invalid = 1'b0; end
      SEG_5: begin digit = 4'd5; invalid = 1'b0; end
      SEG_6: begin digit = 4'd6; invalid = 1'b0; end
      SEG_7: begin digit = 4'd7; invalid = 1'b0; end
      SEG_8: begin digit = 4'd8; invalid = 1'b0; end
      SEG_9: begin digit = 4'd9; invalid = 1'b0; end
      default: begin digit = DIGIT_ERR; invalid = 1'b1; end
    endcase
  end

endmodule

// File: rtl/seg7_reader.sv
// rtl/seg7_reader.sv - glitch-filtered 7-segment bus reader with valid/ready report
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int  STABLE_CYCLES = 4,
  localparam int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] seg_in,
  output logic [3:0] out_digit,
  output logic       out_err,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       overrun,
  input  logic       clr_overrun
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  state_t           state, state_next;
  logic [6:0]       cand;
  logic [6:0]       last;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             changed;
  logic             qualify;
  logic             report;
  logic [3:0]       dec_digit;
  logic             dec_invalid;

  seg7_decode u_decode (
    .seg     (seg_in),
    .digit   (dec_digit),
    .invalid (dec_invalid)
  );

  // At a qualifying edge cand is being loaded with seg_in, so seg_in is decoded directly.
  always_comb begin
    changed    = (seg_in != cand);
    cnt_next   = changed ? CNT_W'(1) : ((cnt == CNT_MAX) ? cnt : cnt + 1'b1);
    qualify    = (cnt_next == CNT_MAX) && ((state == SETTLE) || changed);
    report     = qualify && (seg_in != last) && (seg_in != SEG_BLANK);
    state_next = state;
    if (qualify) begin
      state_next = LOCKED;
    end else if (changed) begin
      state_next = SETTLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= SETTLE;
      cand      <= SEG_BLANK;
      cnt       <= '0;
      last      <= SEG_BLANK;
      out_digit <= 4'd0;
      out_err   <= 1'b0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state <= state_next;
      cand  <= seg_in;
      cnt   <= cnt_next;
      if (qualify) begin
        last <= seg_in;
      end

      if (report && (!out_valid || out_ready)) begin
        out_digit <= dec_digit;
        out_err   <= dec_invalid;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      // A new drop takes priority over a clear in the same cycle.
      if (report && out_valid && !out_ready) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule
